// File: rtl/pointing_pkg.sv
// ---------------------------------------------------------------------------
// pointing_pkg
// Shared definitions for the serial pointing-device emulator:
//   - state_t        : byte-slot state machine states
//   - HDR_FIRST/NEXT : two-bit headers marking the first and follow-on
//                      bytes of a report frame
//   - DEFAULT_*_ID   : device identification bytes for each reporting mode
//   - clamp_axis     : signed step applied to an absolute coordinate,
//                      saturating at 0 and at the axis limit
// ---------------------------------------------------------------------------
package pointing_pkg;

    typedef enum logic [2:0] {
        ST_DEVICE_ID = 3'd0,
        ST_IDLE      = 3'd1,
        ST_BYTE0     = 3'd2,
        ST_BYTE1     = 3'd3,
        ST_BYTE2     = 3'd4,
        ST_BYTE3     = 3'd5
    } state_t;

    localparam logic [1:0] HDR_FIRST = 2'b11;
    localparam logic [1:0] HDR_NEXT  = 2'b10;

    localparam logic [7:0] DEFAULT_REL_ID = 8'hCA;
    localparam logic [7:0] DEFAULT_ABS_ID = 8'hCB;

    // The sum is formed two bits wider than the coordinate so that both an
    // underflow below zero and an overshoot past the limit are visible
    // before saturation, instead of wrapping around.
    function automatic logic [9:0] clamp_axis(input logic [9:0]        pos,
                                              input logic signed [7:0] step,
                                              input logic [9:0]        limit);
        logic signed [11:0] sum;
        sum = $signed({2'b00, pos}) + $signed({{4{step[7]}}, step});
        if (sum < 0) begin
            return '0;
        end else if (sum > $signed({2'b00, limit})) begin
            return limit;
        end else begin
            return sum[9:0];
        end
    endfunction

endpackage

// File: rtl/pointing_accel.sv
// ---------------------------------------------------------------------------
// pointing_accel
// Joystick acceleration: counts how many consecutive frame-load points have
// seen a direction held and picks the step magnitude from that count.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   load        : one-cycle strobe at each frame-load point
//   any_dir     : at least one direction is held
//   overclock   : selects the overclocked fast speed
//   speed       : signed step magnitude to use at this load point
// ---------------------------------------------------------------------------
module pointing_accel #(
    parameter int                ACCEL_SLOTS   = 5,
    parameter logic signed [7:0] SLOW_SPEED    = 8'sd2,
    parameter logic signed [7:0] FAST_SPEED    = 8'sd8,
    parameter logic signed [7:0] FAST_SPEED_OC = 8'sd7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              any_dir,
    input  logic              overclock,
    output logic signed [7:0] speed
);

    logic [2:0] accel;

    // Saturating hold counter; any load point with no direction held
    // starts the ramp over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accel <= '0;
        end else if (load) begin
            if (!any_dir) begin
                accel <= '0;
            end else if (accel != 3'd7) begin
                accel <= accel + 3'd1;
            end
        end
    end

    // Speed is taken from the count held before the current load point,
    // so the first ACCEL_SLOTS held frames all move at the slow speed.
    always_comb begin
        if ({29'd0, accel} >= 32'(ACCEL_SLOTS)) begin
            speed = overclock ? FAST_SPEED_OC : FAST_SPEED;
        end else begin
            speed = SLOW_SPEED;
        end
    end

endmodule

// File: rtl/pointing_device_multi.sv
// ---------------------------------------------------------------------------
// pointing_device_multi
// Serial mouse emulator driven by a joystick. Emits one byte per byte slot,
// either a 3-byte relative report or a 4-byte absolute-position report,
// preceded by a device ID whenever the host raises rts or the mode changes.
//
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   mister_joystick   : bit0 right, bit1 left, bit2 down, bit3 up,
//                       bit5 button1, bit4 button2 (other bits ignored)
//   rts               : host request-to-send; high holds the ID state
//   overclock         : shorter byte slots and alternate fast speed
//   abs_mode          : 0 relative reports, 1 absolute reports
//   serial_out_data   : byte to send, valid while serial_out_write is high
//   serial_out_write  : single-cycle write strobe
// ---------------------------------------------------------------------------
module pointing_device_multi
    import pointing_pkg::*;
#(
    parameter int                TICKS_PER_BYTE    = 250000,
    parameter int                TICKS_PER_BYTE_OC = 200000,
    parameter int                ACCEL_SLOTS       = 5,
    parameter logic signed [7:0] SLOW_SPEED        = 8'sd2,
    parameter logic signed [7:0] FAST_SPEED        = 8'sd8,
    parameter logic signed [7:0] FAST_SPEED_OC     = 8'sd7,
    parameter logic [7:0]        REL_ID            = DEFAULT_REL_ID,
    parameter logic [7:0]        ABS_ID            = DEFAULT_ABS_ID,
    parameter logic [9:0]        X_MAX             = 10'd767,
    parameter logic [9:0]        Y_MAX             = 10'd559
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mister_joystick,
    input  logic        rts,
    input  logic        overclock,
    input  logic        abs_mode,
    output logic [7:0]  serial_out_data,
    output logic        serial_out_write
);

    localparam logic [31:0] TICKS_NORM = 32'(TICKS_PER_BYTE);
    localparam logic [31:0] TICKS_FAST = 32'(TICKS_PER_BYTE_OC);

    state_t            state;
    state_t            state_next;
    logic [31:0]       slot_cnt;
    logic              mode_abs;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [9:0]        next_x;
    logic [9:0]        next_y;
    logic [9:0]        last_x;
    logic [9:0]        last_y;
    logic [1:0]        buttons;
    logic [1:0]        last_buttons;
    logic signed [7:0] speed;
    logic signed [7:0] step_x;
    logic signed [7:0] step_y;
    logic signed [7:0] last_step_x;
    logic signed [7:0] last_step_y;
    logic [3:0][7:0]   frame;
    logic [3:0][7:0]   frame_next;
    logic              any_dir;
    logic              slot_zero;
    logic              load_point;
    logic              mode_change;
    logic              frame_load;
    logic              send_frame;
    logic              write_next;
    logic [7:0]        data_next;
    logic              unused_joystick;

    assign unused_joystick = ^mister_joystick[15:6];

    // Byte-slot timer; rts keeps it parked at the full slot length so the
    // first byte after rts drops lands one whole slot later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= TICKS_NORM;
        end else if (rts || slot_cnt == 32'd0) begin
            slot_cnt <= overclock ? TICKS_FAST : TICKS_NORM;
        end else begin
            slot_cnt <= slot_cnt - 32'd1;
        end
    end

    // The frame-load point is the cycle just before the byte action of an
    // idle slot, so a freshly loaded frame starts going out in that slot.
    assign slot_zero   = (slot_cnt == 32'd0);
    assign load_point  = (state == ST_IDLE) && (slot_cnt == 32'd1) && !rts;
    assign mode_change = load_point && (abs_mode != mode_abs);
    assign frame_load  = load_point && !mode_change;

    assign any_dir = |mister_joystick[3:0];
    assign buttons = {mister_joystick[5], mister_joystick[4]};

    pointing_accel #(
        .ACCEL_SLOTS   (ACCEL_SLOTS),
        .SLOW_SPEED    (SLOW_SPEED),
        .FAST_SPEED    (FAST_SPEED),
        .FAST_SPEED_OC (FAST_SPEED_OC)
    ) u_accel (
        .clk       (clk),
        .reset     (reset),
        .load      (load_point),
        .any_dir   (any_dir),
        .overclock (overclock),
        .speed     (speed)
    );

    // Left wins over right and up wins over down when both are pressed.
    always_comb begin
        step_x = '0;
        step_y = '0;
        if (mister_joystick[1]) begin
            step_x = -speed;
        end else if (mister_joystick[0]) begin
            step_x = speed;
        end
        if (mister_joystick[3]) begin
            step_y = -speed;
        end else if (mister_joystick[2]) begin
            step_y = speed;
        end
    end

    assign next_x = clamp_axis(pos_x, step_x, X_MAX);
    assign next_y = clamp_axis(pos_y, step_y, Y_MAX);

    // Relative mode keeps reporting while moving so the host sees every
    // step; absolute mode only reports a change of state.
    always_comb begin
        if (mode_abs) begin
            send_frame = (next_x != last_x) || (next_y != last_y) ||
                         (buttons != last_buttons);
        end else begin
            send_frame = (buttons != last_buttons) ||
                         (step_x != last_step_x) || (step_y != last_step_y) ||
                         (|step_x) || (|step_y);
        end
    end

    always_comb begin
        frame_next = '0;
        if (mode_abs) begin
            frame_next[0] = {HDR_FIRST, buttons, next_y[9:8], next_x[9:8]};
            frame_next[1] = {HDR_NEXT, next_x[7:2]};
            frame_next[2] = {HDR_NEXT, next_y[7:2]};
            frame_next[3] = {HDR_NEXT, next_x[1:0], next_y[1:0], 2'b00};
        end else begin
            frame_next[0] = {HDR_FIRST, buttons, step_y[7:6], step_x[7:6]};
            frame_next[1] = {HDR_NEXT, step_x[5:0]};
            frame_next[2] = {HDR_NEXT, step_y[5:0]};
        end
    end

    // Everything a frame depends on is captured in the single load cycle,
    // so a frame already on the wire is never altered by later input.
    // Last-sent values track what was loaded, so an aborted frame is not
    // repeated once the device comes back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_abs     <= abs_mode;
            pos_x        <= X_MAX >> 1;
            pos_y        <= Y_MAX >> 1;
            last_x       <= '0;
            last_y       <= '0;
            last_buttons <= '0;
            last_step_x  <= '0;
            last_step_y  <= '0;
            frame        <= '0;
        end else if (mode_change) begin
            mode_abs <= abs_mode;
        end else if (frame_load) begin
            if (mode_abs) begin
                pos_x <= next_x;
                pos_y <= next_y;
            end
            if (send_frame) begin
                frame        <= frame_next;
                last_buttons <= buttons;
                if (mode_abs) begin
                    last_x <= next_x;
                    last_y <= next_y;
                end else begin
                    last_step_x <= step_x;
                    last_step_y <= step_y;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_DEVICE_ID;
        end else begin
            state <= state_next;
        end
    end

    // rts overrides everything and aborts any frame in flight.
    always_comb begin
        state_next = state;
        if (rts || mode_change) begin
            state_next = ST_DEVICE_ID;
        end else if (frame_load && send_frame) begin
            state_next = ST_BYTE0;
        end else if (slot_zero) begin
            case (state)
                ST_DEVICE_ID: state_next = ST_IDLE;
                ST_BYTE0:     state_next = ST_BYTE1;
                ST_BYTE1:     state_next = ST_BYTE2;
                ST_BYTE2:     state_next = mode_abs ? ST_BYTE3 : ST_IDLE;
                ST_BYTE3:     state_next = ST_IDLE;
                default:      state_next = state;
            endcase
        end
    end

    // Data holds its last value between strobes.
    always_comb begin
        write_next = 1'b0;
        data_next  = serial_out_data;
        if (!rts && slot_zero) begin
            case (state)
                ST_DEVICE_ID: begin
                    write_next = 1'b1;
                    data_next  = mode_abs ? ABS_ID : REL_ID;
                end
                ST_BYTE0: begin
                    write_next = 1'b1;
                    data_next  = frame[0];
                end
                ST_BYTE1: begin
                    write_next = 1'b1;
                    data_next  = frame[1];
                end
                ST_BYTE2: begin
                    write_next = 1'b1;
                    data_next  = frame[2];
                end
                ST_BYTE3: begin
                    write_next = 1'b1;
                    data_next  = frame[3];
                end
                default: begin
                    write_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_out_write <= 1'b0;
            serial_out_data  <= '0;
        end else begin
            serial_out_write <= write_next;
            serial_out_data  <= data_next;
        end
    end

endmodule

// File: tb/tb_pointing_device_multi.sv
// ---------------------------------------------------------------------------
// tb_pointing_device_multi
// Drives the emulator one byte slot at a time. A slot-level reference model
// predicts each byte and the cycle it must appear on; a monitor compares
// every write strobe against the queue of predictions.
// ---------------------------------------------------------------------------
module tb_pointing_device_multi;

    localparam int TICKS    = 10;
    localparam int TICKS_OC = 8;
    localparam int X_LIM    = 767;
    localparam int Y_LIM    = 559;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rts;
    logic        overclock;
    logic        abs_mode;
    logic [15:0] joystick;
    logic [7:0]  serial_data;
    logic        serial_write;

    expect_t     exp_q[$];
    expect_t     mon_e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          monitor_on = 1'b0;
    int          slot_start = 0;

    // Reference model state, at the level of slots and whole reports.
    bit          m_abs;
    int          m_x;
    int          m_y;
    int          m_accel;
    int          m_last_btn;
    int          m_last_dx;
    int          m_last_dy;
    int          m_last_x;
    int          m_last_y;
    int          m_pending[$];

    pointing_device_multi #(
        .TICKS_PER_BYTE    (TICKS),
        .TICKS_PER_BYTE_OC (TICKS_OC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .mister_joystick  (joystick),
        .rts              (rts),
        .overclock        (overclock),
        .abs_mode         (abs_mode),
        .serial_out_data  (serial_data),
        .serial_out_write (serial_write)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest prediction in both value
    // and cycle; a prediction whose cycle passes without a strobe is missed.
    always @(negedge clk) begin
        if (monitor_on) begin
            if (serial_write) begin
                if (exp_q.size() == 0) begin
                    check_output("write_when_silent", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("byte_data", int'(serial_data), int'(mon_e.data));
                    check_output("byte_cycle", cyc, mon_e.cyc);
                end
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
                check_output("missing_write", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic void model_emit(input int b, input int at);
        expect_t e;
        e.data = 8'(b);
        e.cyc  = at;
        exp_q.push_back(e);
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // One byte slot of the device: either the next byte of a report already
    // under way, or (when idle) a load decision at the end of the slot.
    function automatic void model_slot(input logic [15:0] j, input bit abs_in,
                                       input bit oc, input int end_cyc);
        int spd, dx, dy, btn, xb, yb, nx, ny;
        if (m_pending.size() > 0) begin
            model_emit(m_pending.pop_front(), end_cyc);
            return;
        end
        spd = (m_accel >= 5) ? (oc ? 7 : 8) : 2;
        if (j[3:0] != 4'd0) m_accel = (m_accel < 7) ? m_accel + 1 : 7;
        else m_accel = 0;
        if (abs_in != m_abs) begin
            m_abs = abs_in;
            model_emit(m_abs ? 'hCB : 'hCA, end_cyc);
            return;
        end
        dx  = j[1] ? -spd : (j[0] ? spd : 0);
        dy  = j[3] ? -spd : (j[2] ? spd : 0);
        btn = (j[5] ? 2 : 0) + (j[4] ? 1 : 0);
        if (!m_abs) begin
            if (btn != m_last_btn || dx != m_last_dx || dy != m_last_dy || dx != 0 || dy != 0) begin
                xb = dx & 255;
                yb = dy & 255;
                model_emit(192 + btn * 16 + (yb / 64) * 4 + xb / 64, end_cyc);
                m_pending.push_back(128 + xb % 64);
                m_pending.push_back(128 + yb % 64);
                m_last_btn = btn;
                m_last_dx  = dx;
                m_last_dy  = dy;
            end
        end else begin
            nx  = clamp(m_x + dx, X_LIM);
            ny  = clamp(m_y + dy, Y_LIM);
            m_x = nx;
            m_y = ny;
            if (nx != m_last_x || ny != m_last_y || btn != m_last_btn) begin
                model_emit(192 + btn * 16 + (ny / 256) * 4 + nx / 256, end_cyc);
                m_pending.push_back(128 + (nx % 256) / 4);
                m_pending.push_back(128 + (ny % 256) / 4);
                m_pending.push_back(128 + (nx % 4) * 16 + (ny % 4) * 4);
                m_last_btn = btn;
                m_last_x   = nx;
                m_last_y   = ny;
            end
        end
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after an edge that sampled rts high; the ID goes out one
    // full slot after the release.
    task automatic release_rts();
        rts        = 1'b0;
        slot_start = cyc;
        m_pending.delete();
        m_pending.push_back(m_abs ? 'hCB : 'hCA);
    endtask

    // The slot length was fixed by the overclock level at the reload edge,
    // so it is taken before the new inputs are applied.
    task automatic apply_stimulus(input logic [15:0] j, input bit abs_in, input bit oc);
        int len;
        len       = (overclock ? TICKS_OC : TICKS) + 1;
        joystick  = j;
        abs_mode  = abs_in;
        overclock = oc;
        model_slot(j, abs_in, oc, slot_start + len);
        wait_until(slot_start + len);
        slot_start = slot_start + len;
    endtask

    task automatic run_slots(input logic [15:0] j, input bit abs_in, input bit oc, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(j, abs_in, oc);
    endtask

    // Raises rts k cycles into a slot, before its load point, so the slot
    // produces nothing and any report in flight is dropped.
    task automatic abort_slot(input logic [15:0] j, input bit abs_in, input bit oc, input int k);
        joystick  = j;
        abs_mode  = abs_in;
        overclock = oc;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        rts = 1'b1;
        m_pending.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        release_rts();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] j;
        bit          a;
        bit          o;
        reset      = 1'b1;
        rts        = 1'b1;
        joystick   = '0;
        abs_mode   = 1'b0;
        overclock  = 1'b0;
        m_abs      = 1'b0;
        m_x        = X_LIM / 2;
        m_y        = Y_LIM / 2;
        m_accel    = 0;
        m_last_btn = 0;
        m_last_dx  = 0;
        m_last_dy  = 0;
        m_last_x   = 0;
        m_last_y   = 0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_write", int'(serial_write), 0);
        check_output("reset_data", int'(serial_data), 0);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        monitor_on = 1'b1;

        $display("[TB] ID after rts release, then idle");
        release_rts();
        run_slots(16'h0000, 1'b0, 1'b0, 4);

        $display("[TB] relative: right held, acceleration, overclock");
        run_slots(16'h0001, 1'b0, 1'b0, 21);
        run_slots(16'h0001, 1'b0, 1'b1, 6);
        run_slots(16'h0000, 1'b0, 1'b0, 6);

        $display("[TB] relative: button1 press and release");
        run_slots(16'h0020, 1'b0, 1'b0, 3);
        run_slots(16'h0000, 1'b0, 1'b0, 6);

        $display("[TB] relative: random joystick");
        for (int i = 0; i < 40; i++) begin
            j = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'hFFFF));
            o = ($urandom_range(0, 3) == 0);
            apply_stimulus(j, 1'b0, o);
        end
        run_slots(16'h0000, 1'b0, 1'b0, 6);

        $display("[TB] absolute: mode switch, up to top edge, right to right edge");
        run_slots(16'h0000, 1'b1, 1'b0, 4);
        run_slots(16'h0008, 1'b1, 1'b0, 170);
        run_slots(16'h0001, 1'b1, 1'b0, 230);

        $display("[TB] absolute: abort during second byte");
        apply_stimulus(16'h0021, 1'b1, 1'b0);
        abort_slot(16'h0021, 1'b1, 1'b0, 3);
        run_slots(16'h0021, 1'b1, 1'b0, 3);
        run_slots(16'h0000, 1'b1, 1'b0, 6);

        $display("[TB] mixed random traffic");
        for (int i = 0; i < 80; i++) begin
            j = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 16'hFFFF));
            a = ($urandom_range(0, 7) == 0) ? !abs_mode : abs_mode;
            o = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                abort_slot(j, a, o, $urandom_range(1, 5));
            end else begin
                apply_stimulus(j, a, o);
            end
        end
        run_slots(16'h0000, abs_mode, 1'b0, 8);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_output("expect_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
